// File: rtl/mem_arbiter.sv
// Arbiter sharing one registered memory port between the I-cache and D-cache.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed D-cache priority.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read_i,
    input  logic [ADDR_W-1:0] i_addr_i,
    output logic [DATA_W-1:0] i_rdata_o,
    output logic              i_ready_o,
    input  logic              d_read_i,
    input  logic              d_write_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              d_ready_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [1:0]        grant_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

`ifdef MEM_ARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    state_t              r_state;
    state_t              w_next;
    logic                r_mem_read;
    logic                r_mem_write;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_last_d;
    logic                w_i_req;
    logic                w_d_req;
    logic                w_tie_d;

    assign w_i_req = i_read_i;
    assign w_d_req = d_read_i | d_write_i;
    // Tie winner: opposite of last-served under round-robin, otherwise always D.
    assign w_tie_d = RR_EN ? ~r_last_d : 1'b1;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_d_req && !w_i_req)      w_next = GNT_D;
                else if (w_i_req && !w_d_req) w_next = GNT_I;
                else if (w_i_req && w_d_req)  w_next = w_tie_d ? GNT_D : GNT_I;
            end
            GNT_I:   if (mem_ready_i) w_next = IDLE;
            GNT_D:   if (mem_ready_i) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_last_d    <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (w_next == GNT_I) begin
                        r_mem_read  <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_mem_addr  <= i_addr_i;
                    end else if (w_next == GNT_D) begin
                        r_mem_read  <= d_read_i & ~d_write_i;
                        r_mem_write <= d_write_i;
                        r_mem_addr  <= d_addr_i;
                        r_mem_wdata <= d_wdata_i;
                    end
                end
                GNT_I: begin
                    if (mem_ready_i) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_last_d    <= 1'b0;
                    end
                end
                GNT_D: begin
                    if (mem_ready_i) begin
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_last_d    <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign i_ready_o   = (r_state == GNT_I) & mem_ready_i;
    assign d_ready_o   = (r_state == GNT_D) & mem_ready_i;
    assign i_rdata_o   = mem_rdata_i;
    assign d_rdata_o   = mem_rdata_i;
    assign mem_read_o  = r_mem_read;
    assign mem_write_o = r_mem_write;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign grant_o     = r_state;

endmodule
